// File: rtl/spell_mem_ctrl.sv
// Registered memory controller for the Spell CPU: routes code/data/IO requests to a
// Wishbone SRAM master, an IO port or a local port, with a one-word read line buffer and timeout.
module spell_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned IO_BASE         = 'h20,
  parameter int unsigned IO_LIMIT        = 'h60,
  parameter int unsigned SRAM_ADDR_WIDTH = 10,
  parameter int unsigned TIMEOUT_CYCLES  = 15
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       sram_enable,
  input  logic                       select,
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic [7:0]                 data_in,
  input  logic                       memory_type_data,
  input  logic                       write,
  output logic [7:0]                 data_out,
  output logic                       data_ready,
  output logic                       error,
  output logic                       io_sel_o,
  output logic                       io_we_o,
  output logic [ADDR_WIDTH-1:0]      io_addr_o,
  output logic [7:0]                 io_dat_o,
  input  logic [7:0]                 io_dat_i,
  input  logic                       io_ready_i,
  output logic                       loc_sel_o,
  output logic                       loc_we_o,
  output logic                       loc_type_o,
  output logic [ADDR_WIDTH-1:0]      loc_addr_o,
  output logic [7:0]                 loc_dat_o,
  input  logic [7:0]                 loc_dat_i,
  input  logic                       loc_ready_i,
  output logic                       sram_cyc_o,
  output logic                       sram_stb_o,
  output logic                       sram_we_o,
  output logic [3:0]                 sram_sel_o,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr_o,
  output logic [31:0]                sram_dat_o,
  input  logic [31:0]                sram_dat_i,
  input  logic                       sram_ack_i
);

  localparam int unsigned AW = ADDR_WIDTH;
  localparam int unsigned TW = AW - 1;

  typedef enum logic [2:0] {IDLE, SRAM_WAIT, IO_WAIT, LOC_WAIT, DONE} state_e;

  state_e        state_q, state_d;
  logic          rearm_q, rearm_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wdat_q, wdat_d;
  logic          type_q, type_d;
  logic          we_q, we_d;
  logic [7:0]    tmo_q, tmo_d;
  logic          lb_valid_q, lb_valid_d;
  logic [TW-1:0] lb_tag_q, lb_tag_d;
  logic [31:0]   lb_data_q, lb_data_d;
  logic [7:0]    dout_q, dout_d;
  logic          rdy_q, rdy_d;
  logic          err_q, err_d;
  logic          io_sel_q, io_sel_d;
  logic          loc_sel_q, loc_sel_d;
  logic          sram_cyc_q, sram_cyc_d;
  logic [3:0]    sram_sel_q, sram_sel_d;

  logic          accept, is_io, lb_hit, target_ack, tmo_expired;
  logic [TW-1:0] req_tag, tag_q;

  function automatic logic [7:0] lane(input logic [31:0] w, input logic [1:0] i);
    return w[{i, 3'b000} +: 8];
  endfunction

  assign accept      = (state_q == IDLE) && select && rearm_q;
  assign is_io       = memory_type_data && (32'(addr) >= IO_BASE) && (32'(addr) < IO_LIMIT);
  assign req_tag     = {memory_type_data, addr[AW-1:2]};
  assign tag_q       = {type_q, addr_q[AW-1:2]};
  assign lb_hit      = lb_valid_q && (lb_tag_q == req_tag) && !write;
  assign tmo_expired = tmo_q >= 8'(TIMEOUT_CYCLES - 1);

  always_comb begin
    target_ack = 1'b0;
    unique case (state_q)
      SRAM_WAIT: target_ack = sram_ack_i;
      IO_WAIT:   target_ack = io_ready_i;
      LOC_WAIT:  target_ack = loc_ready_i;
      default:   target_ack = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_io)             state_d = IO_WAIT;
          else if (!sram_enable) state_d = LOC_WAIT;
          else if (lb_hit)       state_d = DONE;
          else                   state_d = SRAM_WAIT;
        end
      end
      SRAM_WAIT, IO_WAIT, LOC_WAIT: if (target_ack || tmo_expired) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rearm_d    = rearm_q;
    addr_d     = addr_q;
    wdat_d     = wdat_q;
    type_d     = type_q;
    we_d       = we_q;
    tmo_d      = tmo_q;
    lb_valid_d = lb_valid_q;
    lb_tag_d   = lb_tag_q;
    lb_data_d  = lb_data_q;
    dout_d     = dout_q;
    rdy_d      = 1'b0;
    err_d      = 1'b0;
    io_sel_d   = io_sel_q;
    loc_sel_d  = loc_sel_q;
    sram_cyc_d = sram_cyc_q;
    sram_sel_d = sram_sel_q;

    // A held select must drop once before another request is taken.
    if (accept)       rearm_d = 1'b0;
    else if (!select) rearm_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d = addr;
          wdat_d = data_in;
          type_d = memory_type_data;
          we_d   = write;
          tmo_d  = '0;
          if (is_io)             io_sel_d  = 1'b1;
          else if (!sram_enable) loc_sel_d = 1'b1;
          else if (lb_hit) begin
            dout_d = lane(lb_data_q, addr[1:0]);
            rdy_d  = 1'b1;
          end else begin
            sram_cyc_d = 1'b1;
            sram_sel_d = 4'b0001 << addr[1:0];
          end
        end
      end
      SRAM_WAIT, IO_WAIT, LOC_WAIT: begin
        tmo_d = tmo_q + 8'd1;
        if (target_ack || tmo_expired) begin
          io_sel_d   = 1'b0;
          loc_sel_d  = 1'b0;
          sram_cyc_d = 1'b0;
          sram_sel_d = '0;
          rdy_d      = 1'b1;
        end
        if (target_ack) begin
          if (we_q)                       dout_d = '0;
          else if (state_q == SRAM_WAIT)  dout_d = lane(sram_dat_i, addr_q[1:0]);
          else if (state_q == IO_WAIT)    dout_d = io_dat_i;
          else                            dout_d = loc_dat_i;
          if (state_q == SRAM_WAIT) begin
            if (!we_q) begin
              lb_valid_d = 1'b1;
              lb_tag_d   = tag_q;
              lb_data_d  = sram_dat_i;
            end else if (lb_valid_q && (lb_tag_q == tag_q)) begin
              lb_data_d[{addr_q[1:0], 3'b000} +: 8] = wdat_q;
            end
          end
        end else if (tmo_expired) begin
          err_d  = 1'b1;
          dout_d = we_q ? 8'h00 : 8'hFF;
          if (state_q == SRAM_WAIT) lb_valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    if (!sram_enable) lb_valid_d = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rearm_q    <= 1'b1;
      addr_q     <= '0;
      wdat_q     <= '0;
      type_q     <= 1'b0;
      we_q       <= 1'b0;
      tmo_q      <= '0;
      lb_valid_q <= 1'b0;
      lb_tag_q   <= '0;
      lb_data_q  <= '0;
      dout_q     <= '0;
      rdy_q      <= 1'b0;
      err_q      <= 1'b0;
      io_sel_q   <= 1'b0;
      loc_sel_q  <= 1'b0;
      sram_cyc_q <= 1'b0;
      sram_sel_q <= '0;
    end else begin
      rearm_q    <= rearm_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      type_q     <= type_d;
      we_q       <= we_d;
      tmo_q      <= tmo_d;
      lb_valid_q <= lb_valid_d;
      lb_tag_q   <= lb_tag_d;
      lb_data_q  <= lb_data_d;
      dout_q     <= dout_d;
      rdy_q      <= rdy_d;
      err_q      <= err_d;
      io_sel_q   <= io_sel_d;
      loc_sel_q  <= loc_sel_d;
      sram_cyc_q <= sram_cyc_d;
      sram_sel_q <= sram_sel_d;
    end
  end

  assign data_out    = dout_q;
  assign data_ready  = rdy_q;
  assign error       = err_q;
  assign io_sel_o    = io_sel_q;
  assign io_we_o     = io_sel_q & we_q;
  assign io_addr_o   = addr_q;
  assign io_dat_o    = wdat_q;
  assign loc_sel_o   = loc_sel_q;
  assign loc_we_o    = loc_sel_q & we_q;
  assign loc_type_o  = type_q;
  assign loc_addr_o  = addr_q;
  assign loc_dat_o   = wdat_q;
  assign sram_cyc_o  = sram_cyc_q;
  assign sram_stb_o  = sram_cyc_q;
  assign sram_we_o   = sram_cyc_q & we_q;
  assign sram_sel_o  = sram_sel_q;
  assign sram_addr_o = SRAM_ADDR_WIDTH'({type_q, addr_q[AW-1:2], 2'b00});
  assign sram_dat_o  = {4{wdat_q}};

endmodule

// File: tb/tb_spell_mem_ctrl.sv
// Directed bench for spell_mem_ctrl: stimulus pushes expected completions into a queue,
// a monitor pops and compares on every data_ready pulse.
module tb_spell_mem_ctrl;

  localparam int TO     = 15;
  localparam int T_SRAM = 0;
  localparam int T_IO   = 1;
  localparam int T_LOC  = 2;
  localparam int T_HIT  = 3;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        sram_enable, select, memory_type_data, write;
  logic [7:0]  addr, data_in;
  logic [7:0]  data_out;
  logic        data_ready, error;
  logic        io_sel_o, io_we_o, io_ready_i;
  logic [7:0]  io_addr_o, io_dat_o, io_dat_i;
  logic        loc_sel_o, loc_we_o, loc_type_o, loc_ready_i;
  logic [7:0]  loc_addr_o, loc_dat_o, loc_dat_i;
  logic        sram_cyc_o, sram_stb_o, sram_we_o, sram_ack_i;
  logic [3:0]  sram_sel_o;
  logic [9:0]  sram_addr_o;
  logic [31:0] sram_dat_o, sram_dat_i;

  typedef struct packed {
    logic [7:0] d;
    logic       e;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  spell_mem_ctrl #(
    .ADDR_WIDTH(8), .IO_BASE('h20), .IO_LIMIT('h60),
    .SRAM_ADDR_WIDTH(10), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset_n(reset_n), .sram_enable(sram_enable), .select(select),
    .addr(addr), .data_in(data_in), .memory_type_data(memory_type_data), .write(write),
    .data_out(data_out), .data_ready(data_ready), .error(error),
    .io_sel_o(io_sel_o), .io_we_o(io_we_o), .io_addr_o(io_addr_o), .io_dat_o(io_dat_o),
    .io_dat_i(io_dat_i), .io_ready_i(io_ready_i),
    .loc_sel_o(loc_sel_o), .loc_we_o(loc_we_o), .loc_type_o(loc_type_o),
    .loc_addr_o(loc_addr_o), .loc_dat_o(loc_dat_o), .loc_dat_i(loc_dat_i),
    .loc_ready_i(loc_ready_i),
    .sram_cyc_o(sram_cyc_o), .sram_stb_o(sram_stb_o), .sram_we_o(sram_we_o),
    .sram_sel_o(sram_sel_o), .sram_addr_o(sram_addr_o), .sram_dat_o(sram_dat_o),
    .sram_dat_i(sram_dat_i), .sram_ack_i(sram_ack_i)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset_n === 1'b1 && data_ready === 1'b1) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_data_ready: got data_ready=1 with data_out='h%0h, expected no completion", data_out);
        end else begin
          e = q.pop_front();
          chk("data_out", data_out, e.d);
          chk("error", error, e.e);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // wait_n < 0 means the target never responds.
  task automatic access(input logic [7:0] a, input logic [7:0] wd, input logic dt,
                        input logic wr, input int tgt, input int wait_n,
                        input logic [31:0] rd, input logic [9:0] esa, input logic [3:0] esel,
                        input logic [7:0] ed, input logic ee);
    exp_t x;
    int   n;
    x.d = ed;
    x.e = ee;
    q.push_back(x);
    addr = a; data_in = wd; memory_type_data = dt; write = wr; select = 1'b1;
    @(negedge clock);
    select = 1'b0;
    case (tgt)
      T_HIT: begin
        chk("hit_no_cyc", sram_cyc_o, 1'b0);
        chk("hit_latency", data_ready, 1'b1);
      end
      T_SRAM: begin
        chk("sram_cyc_stb", {sram_cyc_o, sram_stb_o}, 2'b11);
        chk("sram_addr", sram_addr_o, esa);
        chk("sram_sel", sram_sel_o, esel);
        chk("sram_we", sram_we_o, wr);
        chk("sram_dat", sram_dat_o, {4{wd}});
      end
      T_IO: begin
        chk("io_sel", io_sel_o, 1'b1);
        chk("io_addr", io_addr_o, a);
        chk("io_we", io_we_o, wr);
        chk("io_dat", io_dat_o, wd);
        chk("io_no_cyc", sram_cyc_o, 1'b0);
      end
      default: begin
        chk("loc_sel", loc_sel_o, 1'b1);
        chk("loc_addr", loc_addr_o, a);
        chk("loc_type", loc_type_o, dt);
        chk("loc_we", loc_we_o, wr);
        chk("loc_no_cyc", sram_cyc_o, 1'b0);
      end
    endcase
    if (tgt != T_HIT) begin
      if (wait_n < 0) begin
        n = 0;
        while ((sram_cyc_o || io_sel_o || loc_sel_o) && n < 100) begin
          n++;
          @(negedge clock);
        end
        chk("timeout_wait_cycles", n, TO);
      end else begin
        repeat (wait_n) @(negedge clock);
        case (tgt)
          T_SRAM:  begin sram_ack_i = 1'b1; sram_dat_i = rd; end
          T_IO:    begin io_ready_i = 1'b1; io_dat_i = rd[7:0]; end
          default: begin loc_ready_i = 1'b1; loc_dat_i = rd[7:0]; end
        endcase
        @(negedge clock);
        sram_ack_i = 1'b0; io_ready_i = 1'b0; loc_ready_i = 1'b0;
      end
    end
    @(negedge clock);
  endtask

  initial begin : stimulus
    exp_t x;
    reset_n = 1'b0; sram_enable = 1'b1; select = 1'b0; memory_type_data = 1'b0; write = 1'b0;
    addr = '0; data_in = '0; io_dat_i = '0; io_ready_i = 1'b0; loc_dat_i = '0;
    loc_ready_i = 1'b0; sram_dat_i = '0; sram_ack_i = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_data_ready", data_ready, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_strobes", {sram_cyc_o, sram_stb_o, io_sel_o, loc_sel_o}, 4'b0000);
    chk("rst_sram_sel", sram_sel_o, 4'b0000);
    chk("rst_sram_addr", sram_addr_o, 10'h000);
    reset_n = 1'b1;
    @(negedge clock);

    // IO window and its boundaries
    access(8'h25, 8'h00, 1'b1, 1'b0, T_IO,   2, 32'h3C,        10'h000, 4'h0, 8'h3C, 1'b0);
    access(8'h5F, 8'h00, 1'b1, 1'b0, T_IO,   0, 32'h81,        10'h000, 4'h0, 8'h81, 1'b0);
    access(8'h1F, 8'h00, 1'b1, 1'b0, T_SRAM, 0, 32'h9900AABB,  10'h11C, 4'h8, 8'h99, 1'b0);

    // code read miss then buffer hit
    access(8'h13, 8'h00, 1'b0, 1'b0, T_SRAM, 1, 32'hA1B2C3D4,  10'h010, 4'h8, 8'hA1, 1'b0);
    access(8'h12, 8'h00, 1'b0, 1'b0, T_HIT,  0, 32'h0,         10'h000, 4'h0, 8'hB2, 1'b0);

    // write-through updates the buffered word
    access(8'h60, 8'h00, 1'b1, 1'b0, T_SRAM, 0, 32'h11223344,  10'h160, 4'h1, 8'h44, 1'b0);
    access(8'h61, 8'h5A, 1'b1, 1'b1, T_SRAM, 0, 32'h0,         10'h160, 4'h2, 8'h00, 1'b0);
    access(8'h61, 8'h00, 1'b1, 1'b0, T_HIT,  0, 32'h0,         10'h000, 4'h0, 8'h5A, 1'b0);
    access(8'h62, 8'h00, 1'b1, 1'b0, T_HIT,  0, 32'h0,         10'h000, 4'h0, 8'h22, 1'b0);

    // ack arriving in the last allowed wait cycle wins over the timeout
    access(8'h08, 8'h00, 1'b0, 1'b0, T_SRAM, 14, 32'hDEADBEEF, 10'h008, 4'h1, 8'hEF, 1'b0);

    // SRAM timeout, late ack ignored, buffer invalidated
    access(8'h44, 8'h00, 1'b0, 1'b0, T_SRAM, -1, 32'h0,        10'h044, 4'h1, 8'hFF, 1'b1);
    sram_ack_i = 1'b1; sram_dat_i = 32'hFFFFFFFF;
    repeat (2) @(negedge clock);
    sram_ack_i = 1'b0;
    access(8'h44, 8'h00, 1'b0, 1'b0, T_SRAM, 0, 32'h01020304,  10'h044, 4'h1, 8'h04, 1'b0);
    access(8'h30, 8'hC7, 1'b1, 1'b1, T_IO,   -1, 32'h0,        10'h000, 4'h0, 8'h00, 1'b1);

    // select held across completion, local port with immediate ready
    sram_enable = 1'b0;
    loc_ready_i = 1'b1; loc_dat_i = 8'h77;
    x.d = 8'h77; x.e = 1'b0; q.push_back(x);
    addr = 8'h05; data_in = 8'h00; memory_type_data = 1'b1; write = 1'b0; select = 1'b1;
    @(negedge clock);
    chk("held_loc_sel", loc_sel_o, 1'b1);
    chk("held_loc_type", loc_type_o, 1'b1);
    chk("held_no_cyc", sram_cyc_o, 1'b0);
    repeat (5) @(negedge clock);
    select = 1'b0; loc_ready_i = 1'b0;
    @(negedge clock);
    access(8'h07, 8'h3E, 1'b0, 1'b1, T_LOC,  1, 32'h0,         10'h000, 4'h0, 8'h00, 1'b0);
    sram_enable = 1'b1;
    @(negedge clock);
    access(8'h46, 8'h00, 1'b0, 1'b0, T_SRAM, 0, 32'h0A0B0C0D,  10'h044, 4'h4, 8'h0B, 1'b0);

    // asynchronous reset during SRAM_WAIT
    addr = 8'h50; memory_type_data = 1'b0; write = 1'b0; select = 1'b1;
    @(negedge clock);
    select = 1'b0;
    chk("pre_reset_cyc", sram_cyc_o, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_strobes", {sram_cyc_o, sram_stb_o, data_ready}, 3'b000);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    access(8'h45, 8'h00, 1'b0, 1'b0, T_SRAM, 0, 32'h55667788,  10'h044, 4'h2, 8'h77, 1'b0);

    repeat (3) @(negedge clock);
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
